// File: rtl/state_pkg.sv
// Shared light/controller encodings and the round-robin phase selector
// for the multi-phase traffic controller.
package state_pkg;

    localparam int unsigned MaxPhases = 8;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        StAllRed = 2'd0,
        StGreen  = 2'd1,
        StYellow = 2'd2,
        StWalk   = 2'd3
    } ctrl_state_t;

    // First approach after cur (wrapping) with demand; cur+1 when nobody is waiting.
    // Scanning from the far end lets the nearest requester overwrite the result.
    function automatic logic [2:0] rr_next(input logic [2:0]  cur,
                                           input logic [7:0]  demand,
                                           input int unsigned n);
        logic [2:0] res;
        int         idx;
        res = 3'((int'(cur) + 1) % int'(n));
        for (int k = int'(n); k >= 1; k--) begin
            idx = (int'(cur) + k) % int'(n);
            if (demand[idx[2:0]]) begin
                res = idx[2:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating per-state cycle counter; clear_i restarts it at 0 on the next edge.
module phase_timer #(
    parameter int unsigned TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    output logic [TIMER_W-1:0] timer_o
);

    logic [TIMER_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_o = timer_q;

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Round-robin multi-approach traffic light controller with pedestrian walk phase.
// Outputs are decoded purely from registered state.
module multi_phase_traffic_ctrl
    import state_pkg::*;
#(
    parameter int unsigned NUM_PHASES    = 2,
    parameter int unsigned GREEN_MIN     = 2,
    parameter int unsigned GREEN_MAX     = 3,
    parameter int unsigned YELLOW_TIME   = 1,
    parameter int unsigned ALL_RED_TIME  = 2,
    parameter int unsigned WALK_TIME     = 2,
    parameter int unsigned REST_IN_GREEN = 0,
    parameter int unsigned TIMER_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pedestrian_btn,
    input  logic [NUM_PHASES-1:0]         car_demand,
    output logic [2*NUM_PHASES-1:0]       car_light,
    output logic                          pedestrian_light,
    output logic                          ped_served,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase
);

    localparam int unsigned PW = $clog2(NUM_PHASES);
    localparam longint unsigned TimerMax = (64'd1 << TIMER_W) - 64'd1;
    localparam bit RestInGreen = (REST_IN_GREEN != 0);

    if (NUM_PHASES < 2 || NUM_PHASES > MaxPhases) begin : g_bad_phases
        $error("NUM_PHASES must be in 2..8");
    end
    if (GREEN_MIN < 1 || GREEN_MAX < 1 || YELLOW_TIME < 1 || ALL_RED_TIME < 1 ||
        WALK_TIME < 1) begin : g_bad_time
        $error("all state lengths must be at least 1");
    end
    if (GREEN_MIN > GREEN_MAX) begin : g_bad_green
        $error("GREEN_MIN must not exceed GREEN_MAX");
    end
    if (longint'(GREEN_MAX) > TimerMax || longint'(YELLOW_TIME) > TimerMax ||
        longint'(ALL_RED_TIME) > TimerMax || longint'(WALK_TIME) > TimerMax) begin : g_bad_width
        $error("a state length does not fit in TIMER_W");
    end

    localparam logic [TIMER_W-1:0] GMinM1   = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMaxM1   = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] YellowM1 = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] AllRedM1 = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] WalkM1   = TIMER_W'(WALK_TIME - 1);

    ctrl_state_t          state_q, state_d;
    logic                 ped_req_q, ped_req_d;
    logic [PW-1:0]        active_phase_q, active_phase_d;
    logic [TIMER_W-1:0]   timer;
    logic [NUM_PHASES-1:0] other_demand;
    logic                 competing;
    logic                 state_change;

    phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_change),
        .timer_o (timer)
    );

    assign other_demand = car_demand & ~(NUM_PHASES'(1) << active_phase_q);
    assign competing    = ped_req_q | (|other_demand);
    assign state_change = (state_d != state_q);

    always_comb begin
        state_d        = state_q;
        active_phase_d = active_phase_q;
        unique case (state_q)
            StAllRed: begin
                if (timer == AllRedM1) begin
                    if (ped_req_q) begin
                        state_d = StWalk;
                    end else begin
                        state_d        = StGreen;
                        active_phase_d = PW'(rr_next(3'(active_phase_q), 8'(car_demand),
                                                     NUM_PHASES));
                    end
                end
            end
            StGreen: begin
                if ((competing && timer >= GMinM1) ||
                    (timer >= GMaxM1 && (competing || !RestInGreen))) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (timer == YellowM1) begin
                    state_d = StAllRed;
                end
            end
            StWalk: begin
                if (timer == WalkM1) begin
                    state_d = StAllRed;
                end
            end
            default: state_d = StAllRed;
        endcase
    end

    // A press landing on the WALK entry edge is already being served, so clear wins.
    always_comb begin
        ped_req_d = ped_req_q;
        if (pedestrian_btn && state_q != StWalk) begin
            ped_req_d = 1'b1;
        end
        if (state_d == StWalk && state_q != StWalk) begin
            ped_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StAllRed;
            ped_req_q      <= 1'b0;
            active_phase_q <= PW'(NUM_PHASES - 1);
        end else begin
            state_q        <= state_d;
            ped_req_q      <= ped_req_d;
            active_phase_q <= active_phase_d;
        end
    end

    always_comb begin
        car_light = '0;
        for (int i = 0; i < int'(NUM_PHASES); i++) begin
            car_light[2*i +: 2] = RED;
            if (PW'(i) == active_phase_q) begin
                if (state_q == StGreen) begin
                    car_light[2*i +: 2] = GREEN;
                end else if (state_q == StYellow) begin
                    car_light[2*i +: 2] = YELLOW;
                end
            end
        end
    end

    assign pedestrian_light = (state_q == StWalk);
    assign ped_served       = (state_q == StWalk) && (timer == '0);
    assign active_phase     = active_phase_q;

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Scoreboard bench: two controllers (rest-in-green off/on) share one random/directed
// stimulus stream and are compared every cycle against a behavioural model.
module tb_multi_phase_traffic_ctrl;

    localparam int N    = 3;
    localparam int GMIN = 2;
    localparam int GMAX = 4;
    localparam int YT   = 1;
    localparam int ART  = 1;
    localparam int WT   = 3;

    localparam int M_ALLRED = 0;
    localparam int M_GREEN  = 1;
    localparam int M_YELLOW = 2;
    localparam int M_WALK   = 3;

    typedef struct packed {
        logic [5:0] cl;
        logic       pl;
        logic       ps;
        logic [1:0] ap;
        logic       rq;
    } exp_t;

    typedef struct {
        int mode;
        int age;
        int phase;
        bit req;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pedestrian_btn = 1'b0;
    logic [2:0] car_demand = 3'b000;

    logic [5:0] car_light0, car_light1;
    logic       ped_light0, ped_light1;
    logic       ped_served0, ped_served1;
    logic [1:0] active0, active1;

    exp_t q0[$];
    exp_t q1[$];
    mdl_t mdl[2];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multi_phase_traffic_ctrl #(
        .NUM_PHASES(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT),
        .ALL_RED_TIME(ART), .WALK_TIME(WT), .REST_IN_GREEN(0), .TIMER_W(8)
    ) u_dut0 (
        .clk(clk), .rst(rst), .pedestrian_btn(pedestrian_btn), .car_demand(car_demand),
        .car_light(car_light0), .pedestrian_light(ped_light0), .ped_served(ped_served0),
        .active_phase(active0)
    );

    multi_phase_traffic_ctrl #(
        .NUM_PHASES(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT),
        .ALL_RED_TIME(ART), .WALK_TIME(WT), .REST_IN_GREEN(1), .TIMER_W(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .pedestrian_btn(pedestrian_btn), .car_demand(car_demand),
        .car_light(car_light1), .pedestrian_light(ped_light1), .ped_served(ped_served1),
        .active_phase(active1)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.mode  = M_ALLRED;
        m.age   = 0;
        m.phase = N - 1;
        m.req   = 1'b0;
        return m;
    endfunction

    function automatic int pick(int cur, logic [2:0] d);
        for (int k = 1; k <= N; k++) begin
            if (d[(cur + k) % N]) return (cur + k) % N;
        end
        return (cur + 1) % N;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, bit rig, bit btn, logic [2:0] d);
        mdl_t n;
        bit   comp;
        logic [2:0] others;
        n = m;
        others = d;
        others[m.phase] = 1'b0;
        comp = m.req || (others != 3'b000);
        case (m.mode)
            M_ALLRED: if (m.age == ART - 1) begin
                if (m.req) n.mode = M_WALK;
                else begin
                    n.mode  = M_GREEN;
                    n.phase = pick(m.phase, d);
                end
            end
            M_GREEN: if ((comp && m.age >= GMIN - 1) ||
                         (m.age >= GMAX - 1 && (comp || !rig))) n.mode = M_YELLOW;
            M_YELLOW: if (m.age == YT - 1) n.mode = M_ALLRED;
            default: if (m.age == WT - 1) n.mode = M_ALLRED;
        endcase
        if (n.mode != m.mode) n.age = 0;
        else n.age = (m.age < 255) ? m.age + 1 : 255;
        if (btn && m.mode != M_WALK) n.req = 1'b1;
        if (n.mode == M_WALK && m.mode != M_WALK) n.req = 1'b0;
        return n;
    endfunction

    function automatic exp_t expect_of(mdl_t m);
        exp_t e;
        e.cl = 6'b0;
        if (m.mode == M_GREEN) e.cl[2*m.phase +: 2] = 2'd2;
        if (m.mode == M_YELLOW) e.cl[2*m.phase +: 2] = 2'd1;
        e.pl = (m.mode == M_WALK);
        e.ps = (m.mode == M_WALK) && (m.age == 0);
        e.ap = 2'(m.phase);
        e.rq = m.req;
        return e;
    endfunction

    // One clock of stimulus; expectations describe the cycle these inputs are applied in.
    task automatic step(input bit r, input bit b, input logic [2:0] d);
        @(posedge clk);
        #1;
        rst = r;
        pedestrian_btn = b;
        car_demand = d;
        if (r) begin
            mdl[0] = mdl_reset();
            mdl[1] = mdl_reset();
        end
        q0.push_back(expect_of(mdl[0]));
        q1.push_back(expect_of(mdl[1]));
        if (!r) begin
            mdl[0] = mdl_next(mdl[0], 1'b0, b, d);
            mdl[1] = mdl_next(mdl[1], 1'b1, b, d);
        end
    endtask

    task automatic do_reset(input logic [2:0] d);
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b0, d);
    endtask

    task automatic step_until(input int mode, input int age, input bit b, input logic [2:0] d);
        int guard = 0;
        while (!(mdl[0].mode == mode && (age < 0 || mdl[0].age == age)) && guard < 60) begin
            step(1'b0, b, d);
            guard++;
        end
        if (guard >= 60) begin
            n_err++;
            $display("FAIL step_until timeout: mode %0d never reached, now %0d", mode,
                     mdl[0].mode);
        end
    endtask

    task automatic compare(input int dut, input exp_t e, input exp_t a);
        bit green_seen;
        n_vec++;
        if (a.cl !== e.cl) begin
            n_err++;
            $display("FAIL dut%0d car_light: got %b want %b at %0t", dut, a.cl, e.cl, $time);
        end
        if (a.pl !== e.pl) begin
            n_err++;
            $display("FAIL dut%0d pedestrian_light: got %b want %b at %0t", dut, a.pl, e.pl,
                     $time);
        end
        if (a.ps !== e.ps) begin
            n_err++;
            $display("FAIL dut%0d ped_served: got %b want %b at %0t", dut, a.ps, e.ps, $time);
        end
        if (a.ap !== e.ap) begin
            n_err++;
            $display("FAIL dut%0d active_phase: got %0d want %0d at %0t", dut, a.ap, e.ap,
                     $time);
        end
        if (a.rq !== e.rq) begin
            n_err++;
            $display("FAIL dut%0d ped_req: got %b want %b at %0t", dut, a.rq, e.rq, $time);
        end
        green_seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (a.cl[2*i +: 2] == 2'd2) green_seen = 1'b1;
        end
        if (green_seen && a.pl) begin
            n_err++;
            $display("FAIL dut%0d green_with_walk: got car green and walk together at %0t",
                     dut, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = {car_light0, ped_light0, ped_served0, active0, u_dut0.ped_req_q};
                compare(0, e, a);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {car_light1, ped_light1, ped_served1, active1, u_dut1.ped_req_q};
                compare(1, e, a);
            end
        end
    end

    initial begin : stimulus
        logic [2:0] d;
        mdl[0] = mdl_reset();
        mdl[1] = mdl_reset();

        // Idle round robin; rest-in-green unit sits on phase 0, then demand on phase 1.
        do_reset(3'b000);
        repeat (60) step(1'b0, 1'b0, 3'b000);
        repeat (12) step(1'b0, 1'b0, 3'b010);

        // Pedestrian pulse on the first phase-0 green cycle.
        do_reset(3'b000);
        step(1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b1, 3'b000);
        repeat (20) step(1'b0, 1'b0, 3'b000);

        // Held demand from reset: phase 2 only, then phases 0 and 2.
        do_reset(3'b100);
        repeat (25) step(1'b0, 1'b0, 3'b100);
        repeat (30) step(1'b0, 1'b0, 3'b101);

        // Reset on WALK cycle 2, then plain restart.
        do_reset(3'b000);
        step(1'b0, 1'b1, 3'b000);
        step_until(M_WALK, 1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 3'b000);
        repeat (20) step(1'b0, 1'b0, 3'b000);

        // Button held through WALK, released on the following ALL_RED.
        step_until(M_WALK, -1, 1'b1, 3'b000);
        while (mdl[0].mode == M_WALK) step(1'b0, 1'b1, 3'b000);
        repeat (20) step(1'b0, 1'b0, 3'b000);

        // Button held into that ALL_RED: a fresh request after the next green.
        step_until(M_WALK, -1, 1'b1, 3'b000);
        while (mdl[0].mode == M_WALK) step(1'b0, 1'b1, 3'b000);
        step(1'b0, 1'b1, 3'b000);
        repeat (25) step(1'b0, 1'b0, 3'b000);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            d = 3'($urandom_range(0, 7));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, d);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_phase_traffic_ctrl.md
MULTI_PHASE_TRAFFIC_CTRL -- requirements
Module: multi_phase_traffic_ctrl

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 2, number of car approaches (legal range 2..8).
REQ-002 SHALL have parameter GREEN_MIN, default 2, minimum car green length in cycles.
REQ-003 SHALL have parameter GREEN_MAX, default 3, maximum car green length in cycles when there is competing demand or REST_IN_GREEN=0.
REQ-004 SHALL have parameter YELLOW_TIME, default 1, yellow length in cycles.
REQ-005 SHALL have parameter ALL_RED_TIME, default 2, clearance length in cycles.
REQ-006 SHALL have parameter WALK_TIME, default 2, pedestrian green length in cycles.
REQ-007 SHALL have parameter REST_IN_GREEN, default 0; 1 holds green indefinitely while there is no competing demand.
REQ-008 SHALL have parameter TIMER_W, default 8, state timer width.
REQ-009 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-011 SHALL have port pedestrian_btn, input, 1 bit, pedestrian request (level or pulse).
REQ-012 SHALL have port car_demand, input, NUM_PHASES bits, per-approach vehicle detector.
REQ-013 SHALL have port car_light, output, 2*NUM_PHASES bits, light_t per approach; approach i occupies bits [2i+1:2i].
REQ-014 SHALL have port pedestrian_light, output, 1 bit, 1 = walk (green), 0 = red.
REQ-015 SHALL have port ped_served, output, 1 bit, one-cycle pulse on the first WALK cycle.
REQ-016 SHALL have port active_phase, output, $clog2(NUM_PHASES) bits, index of the approach currently or last served.

Function
REQ-017 SHALL implement controller states ALL_RED, GREEN, YELLOW, WALK; a timer restarts at 0 on every state change, increments each cycle and saturates at all-ones.
REQ-018 SHALL define state length L as exit when timer == L-1, giving exactly L cycles in ALL_RED, YELLOW and WALK.
REQ-019 SHALL define competing demand = ped_req OR any car_demand bit other than active_phase.
REQ-020 SHALL, in GREEN, go to YELLOW when (competing && timer >= GREEN_MIN-1) or (timer >= GREEN_MAX-1 && (competing || !REST_IN_GREEN)).
REQ-021 SHALL go YELLOW -> ALL_RED, and WALK -> ALL_RED.
REQ-022 SHALL, on ALL_RED exit, go to WALK if ped_req is set; otherwise go to GREEN, loading active_phase with the first index after active_phase (round-robin, wrapping modulo NUM_PHASES) whose car_demand bit is 1, or active_phase+1 mod NUM_PHASES if no bit is set.
REQ-023 SHALL set ped_req when pedestrian_btn is high in any state except WALK; presses during WALK are ignored.
REQ-024 SHALL clear ped_req on the WALK entry edge; clear wins over a simultaneous press.
REQ-025 SHALL drive car_light[active_phase] GREEN or YELLOW in GREEN or YELLOW respectively; all other approaches, and all approaches in ALL_RED and WALK, SHALL be RED.
REQ-026 SHALL assert pedestrian_light only in WALK; car green and pedestrian walk SHALL never coexist.
REQ-027 SHALL decode outputs from registered state only, with no combinational input-to-output path.

Reset
REQ-028 SHALL, on rst, asynchronously force: state ALL_RED, timer 0, ped_req 0, active_phase NUM_PHASES-1, all car_light RED, pedestrian_light 0, ped_served 0.
REQ-029 SHALL, on rst mid-operation (any state), abandon the cycle and restart from REQ-028 after release, with the first green on phase 0 when no demand is present.

Structure
REQ-030 SHALL take light_t (RED=0, YELLOW=1, GREEN=2) and ctrl_state_t from the shared state_pkg.
REQ-031 SHALL place the saturating state timer in one sub-module, phase_timer, with TIMER_W as its parameter.
REQ-032 SHALL reject at elaboration: any time < 1, GREEN_MIN > GREEN_MAX, or a maximum time > 2^TIMER_W-1.

Verification
Parameters for scenarios 1-3 and 5-6: NUM_PHASES=3, GREEN_MIN=2, GREEN_MAX=4, YELLOW_TIME=1, ALL_RED_TIME=1, WALK_TIME=3, REST_IN_GREEN=0.
REQ-033 SHALL test: reset, then idle inputs -> ALL_RED 1 cycle, phase0 GREEN 4, YELLOW 1, ALL_RED 1, phase1 GREEN 4, and so on in 0,1,2,0 order.
REQ-034 SHALL test: pedestrian_btn pulse on the first phase0 green cycle -> GREEN 2, YELLOW 1, ALL_RED 1, WALK 3 with ped_served on WALK cycle 1 only, ALL_RED 1, then phase1 GREEN.
REQ-035 SHALL test: car_demand=3'b100 held from reset -> phase2 GREEN first, then phase2 GREEN again (no other demand); with 3'b101 -> phase0 and phase2 alternate and phase1 is never green.
REQ-036 SHALL test: REST_IN_GREEN=1, no demand -> phase0 green for 50 cycles; then car_demand[1]=1 -> YELLOW on the next cycle, then phase1 GREEN after ALL_RED.
REQ-037 SHALL test: rst asserted on WALK cycle 2 -> pedestrian_light, ped_served and ped_req are 0 immediately, all cars RED, and the restart follows REQ-033.
REQ-038 SHALL test: pedestrian_btn held through WALK and released on the ALL_RED after it -> no second WALK; held into that ALL_RED -> WALK follows the next green.
